// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit: bus widths, the
//   default reset PC, the response FIFO entry layout and the clogb2 helper
//   that sizes the instruction RAM address port (also used by the RAM).
package ifu_fetch_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int FIFO_DEPTH = 3;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Number of bits needed to represent value (clogb2(2047) = 11).
    function automatic int clogb2(input int value);
        int v;
        int w;
        v = value;
        w = 0;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
//   Three-entry synchronous FIFO of {pc, inst} fetch responses.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     flush       drop all entries (takes priority over push/pop)
//     push        write push_data at the tail
//     push_data   {pc, inst} entry
//     pop         advance the head (ignored while empty)
//     head        entry at the head, zero while empty
//     valid       FIFO non-empty
//     count       number of stored entries (0..3)
//   The producer guarantees no push while full without a matching pop.
module ifu_fifo
    import ifu_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t mem [FIFO_DEPTH];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign valid  = (count != 2'd0);
    assign do_pop = pop & valid;
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction fetch stage driving read port A of the instruction RAM.
//   One word read per cycle; the RAM's one-cycle read latency is absorbed
//   by a 3-entry response FIFO and a credit rule (count + inflight < 3).
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     jump_req_i      redirect pulse, jump_addr_i is the byte target
//     halt_i          stop issuing; already fetched words still drain
//     ram_ena_o       port-A enable
//     ram_addra_o     port-A word address (wraps modulo RAM size)
//     ram_douta_i     port-A data, valid the cycle after ram_ena_o
//     inst_valid_o    head valid towards decode
//     inst_ready_i    decode accepts head
//     inst_o          head instruction word
//     inst_pc_o       head byte PC
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter  int                     RAM_DEPTH = 2048,
    parameter  logic [InstAddrBus-1:0] RESET_PC  = RESET_PC_DEFAULT,
    localparam int                     AW        = clogb2(RAM_DEPTH - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_req_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    input  logic                   halt_i,
    output logic                   ram_ena_o,
    output logic [AW-1:0]          ram_addra_o,
    input  logic [InstBus-1:0]     ram_douta_i,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output logic [InstBus-1:0]     inst_o,
    output logic [InstAddrBus-1:0] inst_pc_o
);

    logic [InstAddrBus-1:0] pc_q;
    logic [InstAddrBus-1:0] pc_issued_q;
    logic                   inflight_q;

    logic [InstAddrBus-1:0] jump_target;
    logic [InstAddrBus-1:0] issue_pc;
    logic [2:0]             credit_used;
    logic                   issue;
    logic                   push;
    logic [1:0]             fifo_count;
    fetch_entry_t           fifo_head;
    fetch_entry_t           push_data;

    // Word-align the redirect target; the low two bits are ignored.
    assign jump_target = jump_addr_i & ~32'h3;
    assign issue_pc    = jump_req_i ? jump_target : pc_q;
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};

    // A jump flushes the FIFO and kills the in-flight read in the same
    // cycle, so a redirect always has credit for its own target fetch.
    assign issue = !rst && !halt_i && (jump_req_i || (credit_used < 3'd3));

    assign ram_ena_o   = issue;
    assign ram_addra_o = rst ? RESET_PC[AW+1:2] : issue_pc[AW+1:2];

    // Data arriving now belongs to last cycle's issue; a jump this cycle
    // makes it stale, so it is dropped instead of pushed.
    assign push      = inflight_q && !jump_req_i;
    assign push_data = '{pc: pc_issued_q, inst: ram_douta_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pc_issued_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_issued_q <= issue_pc;
                pc_q        <= issue_pc + 32'd4;
            end else if (jump_req_i) begin
                pc_q <= jump_target;
            end
        end
    end

    ifu_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_req_i),
        .push      (push),
        .push_data (push_data),
        .pop       (inst_ready_i),
        .head      (fifo_head),
        .valid     (inst_valid_o),
        .count     (fifo_count)
    );

    assign inst_o    = fifo_head.inst;
    assign inst_pc_o = fifo_head.pc;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that drives the read-only port A of the core's dual-port instruction/data RAM.
- Keeps the fetch PC and issues one word read per cycle.
- Absorbs the RAM's 1-cycle registered read latency into a 3-entry response FIFO.
- Presents {pc, instruction} to decode over a valid/ready handshake, and handles jump/flush redirects and halt.

Parameters:
- RAM_DEPTH, 2048: words in the instruction RAM. AW = clogb2(RAM_DEPTH-1) is the port-A address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- jump_req_i  in  1  redirect request from execute/CSR (1-cycle pulse)
- jump_addr_i  in  32  redirect target byte address
- halt_i  in  1  stop issuing new fetches (debug/wfi); delivery of already-fetched words continues
- ram_ena_o  out  1  port-A enable to RAM
- ram_addra_o  out  AW  port-A word address
- ram_douta_i  in  32  port-A read data, valid the cycle after ram_ena_o=1 and held while ena=0
- inst_valid_o  out  1  FIFO head valid
- inst_ready_i  in  1  decode accepts head
- inst_o  out  32  instruction word at FIFO head
- inst_pc_o  out  32  byte PC of inst_o

Behaviour:
- Reset (rst=1 at a posedge):
  - pc <= RESET_PC; FIFO count <= 0; inflight <= 0; kill <= 0.
  - Outputs: inst_valid_o=0, inst_o=0, inst_pc_o=0, ram_ena_o=0, ram_addra_o=RESET_PC[AW+1:2].
  - Reset mid-operation discards the FIFO and any in-flight read.
- Issue condition: ram_ena_o = !rst & !halt_i & (count + inflight < 3). Computed from registered state only; inst_ready_i never feeds ram_ena_o.
- Issue address and PC update:
  - ram_addra_o = jump_req_i ? jump_addr_i[AW+1:2] : pc[AW+1:2]. Upper bits are dropped, so the address wraps modulo RAM_DEPTH*4.
  - On issue: pc_issued <= issue address (full 32 bits); pc <= issue address + 4; inflight <= 1.
  - No issue: inflight <= 0.
- Response: the cycle after an issue with kill=0, {pc_issued, ram_douta_i} is pushed into the FIFO.
- Latency:
  - Issue in cycle t, push at end of t+1, inst_valid_o=1 in cycle t+2.
  - First valid instruction is 2 cycles after reset release.
  - Steady-state throughput is 1 instruction/cycle with inst_ready_i=1: count 1, inflight 1, so the issue condition holds.
- Handshake:
  - Pop when inst_valid_o & inst_ready_i.
  - inst_o / inst_pc_o stay stable while valid and not ready.
  - Push and pop in the same cycle leave count unchanged.
  - FIFO never overflows: the credit rule guarantees count + inflight <= 3.
- Jump (jump_req_i=1):
  - FIFO flushed (count <= 0).
  - An in-flight read issued before the jump is marked kill <= 1 and its data is dropped next cycle.
  - Jump target issued in the same cycle if !halt_i. After the flush, credits are always available, so the issue check uses post-flush credit.
  - pc <= jump_addr_i + 4 if issued, else pc <= jump_addr_i.
  - jump_addr_i[1:0] are ignored; the PC is forced word aligned.
  - A pop coincident with a jump has no effect.
  - Back-to-back jumps: the latest wins.
- Halt:
  - No new issues; an in-flight read still completes into the FIFO.
  - Deasserting halt_i resumes from pc.
  - A jump while halted updates pc without issuing.
- Widths: pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 = 0.

Decomposition:
- Shared defines:
  - `InstBus` (32), `InstAddrBus` (32).
  - `RESET_PC` default.
  - clogb2 function for address width, shared with the RAM.
- One natural sub-module: ifu_fifo, a 3-entry 64-bit {pc, inst} synchronous FIFO with flush, push, pop and count outputs.

Test Plan:
- Reset release with RAM word0=32'h0000_0013, word1=32'h0010_0093, inst_ready_i=1 -> ram_addra_o=0 in cycle 0, 1 in cycle 1; inst_valid_o in cycle 2 with pc 0 / 32'h13; pc 4 / 32'h0010_0093 in cycle 3; valid continuous afterwards.
- inst_ready_i=0 for 10 cycles -> at most 3 words buffered, ram_ena_o low once count+inflight=3, inst_o stable; on ready=1 the words arrive in order with PCs 0, 4, 8, 12 and no gaps.
- jump_req_i with jump_addr_i=32'h0000_0100 while 2 entries are buffered and 1 is in flight -> the stale in-flight word is never output; the next valid is pc 32'h100 exactly 2 cycles later.
- jump_addr_i=32'h0000_0102 -> fetch address 0x100, inst_pc_o=32'h100.
- halt_i=1 for 5 cycles mid-stream -> no issue, the in-flight word is still delivered; after release fetch resumes at the next sequential PC.
- rst pulse while FIFO is full -> inst_valid_o=0 the next cycle, restart at RESET_PC; wrap test: jump to (RAM_DEPTH*4)-4 -> next ram_addra_o=0, inst_pc_o=RAM_DEPTH*4.
